// File: rtl/paddle_move_scheduler.sv
// Paddle position scheduler: debounces four key inputs, latches one command per
// player on each frame tick and applies them one per clock through a shared write port.
module paddle_move_scheduler #(
   parameter int unsigned Y_MAX  = 112,
   parameter int unsigned Y_INIT = 56,
   parameter int unsigned STEP   = 2,
   parameter int unsigned DEB_N  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] key_up,
   input  logic [1:0] key_dn,
   input  logic       frame_tick,
   input  logic       game_run,
   input  logic       recenter,
   output logic [6:0] pad1_y,
   output logic [6:0] pad2_y,
   output logic       upd_valid,
   output logic       upd_player,
   output logic [6:0] upd_y,
   output logic       tick_overrun,
   output logic [1:0] dbg_state,
   output logic       dbg_rr_ptr
);

   localparam int unsigned   CW       = (DEB_N > 1) ? $clog2(DEB_N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_N - 1);
   localparam logic [7:0]    STEP8    = 8'(STEP);
   localparam logic [7:0]    YMAX8    = 8'(Y_MAX);
   localparam logic [6:0]    YINIT7   = 7'(Y_INIT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB1 = 2'd1,
      ARB2 = 2'd2
   } state_t;

   // Filter bits [1:0] are the up keys, [3:2] the down keys, bit index = player within each pair.
   logic [3:0]    raw;
   logic [3:0]    filt_q, filt_d;
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];

   assign raw = {key_dn, key_up};

   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (raw[i] != filt_q[i]) begin
            if (cnt_q[i] == CNT_LAST) filt_d[i] = raw[i];
            else                      cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   logic [1:0] cmd_up, cmd_dn;
   assign cmd_up = filt_q[1:0] & ~filt_q[3:2];
   assign cmd_dn = filt_q[3:2] & ~filt_q[1:0];

   // Widened to 8 bits so neither the subtract nor the add can wrap before clamping.
   function automatic logic [6:0] next_pos(input logic [6:0] y, input logic up);
      logic [7:0] y8;
      logic [7:0] r;
      y8 = {1'b0, y};
      if (up) r = (y8 < STEP8) ? 8'd0 : (y8 - STEP8);
      else    r = ((y8 + STEP8) > YMAX8) ? YMAX8 : (y8 + STEP8);
      return 7'(r);
   endfunction

   state_t     state_q, state_d;
   logic [1:0] lat_up_q, lat_up_d, lat_dn_q, lat_dn_d;
   logic       rr_q, rr_d;
   logic [6:0] pad1_q, pad1_d, pad2_q, pad2_d;
   logic       upd_valid_q, upd_valid_d, upd_player_q, upd_player_d;
   logic [6:0] upd_y_q, upd_y_d;
   logic       ovr_q, ovr_d;
   logic [1:0] pend;
   logic       grant, gp;
   logic [6:0] new_y;

   assign pend = lat_up_q | lat_dn_q;

   always_comb begin
      state_d      = state_q;
      lat_up_d     = lat_up_q;
      lat_dn_d     = lat_dn_q;
      rr_d         = rr_q;
      pad1_d       = pad1_q;
      pad2_d       = pad2_q;
      upd_valid_d  = 1'b0;
      upd_player_d = 1'b0;
      upd_y_d      = '0;
      grant        = 1'b0;
      gp           = 1'b0;
      new_y        = '0;
      ovr_d        = (state_q != IDLE) && frame_tick && game_run && !recenter;

      case (state_q)
         IDLE: begin
            if (frame_tick && game_run) begin
               lat_up_d = cmd_up;
               lat_dn_d = cmd_dn;
               state_d  = ARB1;
            end
         end
         // Only the first grant of a round moves the priority pointer, so the
         // player served first alternates from one round to the next.
         ARB1: begin
            if (pend == 2'b00) begin
               state_d = IDLE;
            end else begin
               grant   = 1'b1;
               gp      = pend[rr_q] ? rr_q : ~rr_q;
               rr_d    = ~gp;
               state_d = pend[~gp] ? ARB2 : IDLE;
            end
         end
         ARB2: begin
            grant   = (pend != 2'b00);
            gp      = pend[1];
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // upd_valid is a one-cycle strobe with no back-pressure; player and y are
      // meaningful only while it is high and match the pad register shown that cycle.
      if (grant) begin
         new_y = next_pos(gp ? pad2_q : pad1_q, lat_up_q[gp]);
         if (gp) pad2_d = new_y;
         else    pad1_d = new_y;
         lat_up_d[gp] = 1'b0;
         lat_dn_d[gp] = 1'b0;
         upd_valid_d  = 1'b1;
         upd_player_d = gp;
         upd_y_d      = new_y;
      end

      if (recenter) begin
         state_d      = IDLE;
         lat_up_d     = '0;
         lat_dn_d     = '0;
         rr_d         = rr_q;
         pad1_d       = YINIT7;
         pad2_d       = YINIT7;
         upd_valid_d  = 1'b0;
         upd_player_d = 1'b0;
         upd_y_d      = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt_q       <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         state_q      <= IDLE;
         lat_up_q     <= '0;
         lat_dn_q     <= '0;
         rr_q         <= 1'b0;
         pad1_q       <= YINIT7;
         pad2_q       <= YINIT7;
         upd_valid_q  <= 1'b0;
         upd_player_q <= 1'b0;
         upd_y_q      <= '0;
         ovr_q        <= 1'b0;
      end else begin
         filt_q       <= filt_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
         state_q      <= state_d;
         lat_up_q     <= lat_up_d;
         lat_dn_q     <= lat_dn_d;
         rr_q         <= rr_d;
         pad1_q       <= pad1_d;
         pad2_q       <= pad2_d;
         upd_valid_q  <= upd_valid_d;
         upd_player_q <= upd_player_d;
         upd_y_q      <= upd_y_d;
         ovr_q        <= ovr_d;
      end
   end

   assign pad1_y       = pad1_q;
   assign pad2_y       = pad2_q;
   assign upd_valid    = upd_valid_q;
   assign upd_player   = upd_player_q;
   assign upd_y        = upd_y_q;
   assign tick_overrun = ovr_q;
   assign dbg_state    = state_q;
   assign dbg_rr_ptr   = rr_q;

endmodule

// File: tb/tb_paddle_move_scheduler.sv
// Directed bench for paddle_move_scheduler: a default instance for scheduling
// behaviour and a second instance starting at row 1 for the clamp boundaries.
module tb_paddle_move_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] key_up = '0, key_dn = '0;
   logic       frame_tick = 1'b0, game_run = 1'b1, recenter = 1'b0;
   logic [6:0] pad1_y, pad2_y, upd_y;
   logic       upd_valid, upd_player, tick_overrun, dbg_rr_ptr;
   logic [1:0] dbg_state;

   logic [1:0] c_key_up = '0, c_key_dn = '0;
   logic       c_tick = 1'b0, c_run = 1'b1, c_recenter = 1'b0;
   logic [6:0] c_pad1_y, c_pad2_y, c_upd_y;
   logic       c_upd_valid, c_upd_player, c_tick_overrun, c_dbg_rr_ptr;
   logic [1:0] c_dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ovr_cnt  = 0;

   logic       ev_p[$];
   logic [6:0] ev_y[$];
   logic [6:0] ev_pad[$];
   int         ev_cyc[$];

   paddle_move_scheduler dut (
      .clk(clk), .rst(rst), .key_up(key_up), .key_dn(key_dn),
      .frame_tick(frame_tick), .game_run(game_run), .recenter(recenter),
      .pad1_y(pad1_y), .pad2_y(pad2_y), .upd_valid(upd_valid),
      .upd_player(upd_player), .upd_y(upd_y), .tick_overrun(tick_overrun),
      .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
   );

   paddle_move_scheduler #(.Y_INIT(1)) dut_c (
      .clk(clk), .rst(rst), .key_up(c_key_up), .key_dn(c_key_dn),
      .frame_tick(c_tick), .game_run(c_run), .recenter(c_recenter),
      .pad1_y(c_pad1_y), .pad2_y(c_pad2_y), .upd_valid(c_upd_valid),
      .upd_player(c_upd_player), .upd_y(c_upd_y), .tick_overrun(c_tick_overrun),
      .dbg_state(c_dbg_state), .dbg_rr_ptr(c_dbg_rr_ptr)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Event log of every update strobe and overrun pulse on the default instance
   always @(negedge clk) begin
      if (upd_valid) begin
         ev_p.push_back(upd_player);
         ev_y.push_back(upd_y);
         ev_pad.push_back(upd_player ? pad2_y : pad1_y);
         ev_cyc.push_back(cyc);
      end
      if (tick_overrun) ovr_cnt <= ovr_cnt + 1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      key_up = '0; key_dn = '0; frame_tick = 1'b0; recenter = 1'b0; game_run = 1'b1;
      rst = 1'b0;
      step(2);
      rst = 1'b1;
      step(1);
   endtask

   task automatic tick_round(input int wait_n);
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(wait_n);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (pad1_y !== 7'd56) begin n_fail++; $display("FAIL reset_pad1 got %0d exp 56", pad1_y); end
      n_checks++; if (pad2_y !== 7'd56) begin n_fail++; $display("FAIL reset_pad2 got %0d exp 56", pad2_y); end
      n_checks++; if (upd_valid !== 1'b0 || upd_player !== 1'b0 || upd_y !== 7'd0) begin
         n_fail++; $display("FAIL reset_upd got v=%0b p=%0b y=%0d exp 0/0/0", upd_valid, upd_player, upd_y); end
      n_checks++; if (tick_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %0b exp 0", tick_overrun); end
      n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
      n_checks++; if (dbg_rr_ptr !== 1'b0) begin n_fail++; $display("FAIL reset_rr got %0b exp 0", dbg_rr_ptr); end
      n_checks++; if (c_pad1_y !== 7'd1 || c_pad2_y !== 7'd1) begin
         n_fail++; $display("FAIL reset_c_pads got %0d/%0d exp 1/1", c_pad1_y, c_pad2_y); end
      @(posedge clk); #1;
      rst = 1'b1;
      step(1);
   endtask

   task automatic test_debounce();
      int b;
      b = ev_y.size();
      key_up[0] = 1'b1;
      step(2);
      key_up[0] = 1'b0;
      step(1);
      tick_round(4);
      n_checks++; if (ev_y.size() != b) begin n_fail++; $display("FAIL deb_short got %0d updates exp 0", ev_y.size() - b); end
      key_up[0] = 1'b1;
      step(3);
      tick_round(4);
      n_checks++; if (ev_y.size() != b + 1) begin n_fail++; $display("FAIL deb_long_count got %0d exp 1", ev_y.size() - b); end
      else if (ev_p[b] !== 1'b0 || ev_y[b] !== 7'd54 || ev_pad[b] !== 7'd54) begin
         n_fail++; $display("FAIL deb_long got p=%0b y=%0d pad=%0d exp 0/54/54", ev_p[b], ev_y[b], ev_pad[b]); end
   endtask

   task automatic test_round_robin();
      int b;
      logic       exp_p[$];
      logic [6:0] exp_q[$];
      do_reset();
      exp_p = '{1'b0, 1'b1, 1'b1, 1'b0};
      exp_q = '{7'd58, 7'd58, 7'd60, 7'd60};
      b = ev_y.size();
      key_dn = 2'b11;
      step(3);
      tick_round(9);
      tick_round(5);
      n_checks++; if (ev_y.size() - b != exp_q.size()) begin n_fail++; $display("FAIL rr_count got %0d exp 4", ev_y.size() - b); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (b + i >= ev_y.size()) begin n_fail++; $display("FAIL rr_ev%0d missing exp p=%0b y=%0d", i, exp_p[i], exp_q[i]); end
         else if (ev_p[b+i] !== exp_p[i] || ev_y[b+i] !== exp_q[i] || ev_pad[b+i] !== exp_q[i]) begin
            n_fail++; $display("FAIL rr_ev%0d got p=%0b y=%0d pad=%0d exp p=%0b y=%0d", i, ev_p[b+i], ev_y[b+i], ev_pad[b+i], exp_p[i], exp_q[i]); end
      end
      n_checks++;
      if (ev_y.size() >= b + 4 && (ev_cyc[b+1] != ev_cyc[b] + 1 || ev_cyc[b+3] != ev_cyc[b+2] + 1)) begin
         n_fail++; $display("FAIL rr_back_to_back got gaps %0d/%0d exp 1/1", ev_cyc[b+1] - ev_cyc[b], ev_cyc[b+3] - ev_cyc[b+2]); end
      key_dn = 2'b00;
   endtask

   task automatic test_overrun_conflict();
      int b, o;
      do_reset();
      b = ev_y.size();
      o = ovr_cnt;
      key_up = 2'b11;
      step(3);
      frame_tick = 1'b1;
      step(2);
      frame_tick = 1'b0;
      step(5);
      n_checks++; if (ovr_cnt - o != 1) begin n_fail++; $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt - o); end
      n_checks++; if (ev_y.size() - b != 2) begin n_fail++; $display("FAIL ovr_updates got %0d exp 2", ev_y.size() - b); end
      else if (ev_p[b] !== 1'b0 || ev_y[b] !== 7'd54 || ev_p[b+1] !== 1'b1 || ev_y[b+1] !== 7'd54) begin
         n_fail++; $display("FAIL ovr_order got %0b:%0d %0b:%0d exp 0:54 1:54", ev_p[b], ev_y[b], ev_p[b+1], ev_y[b+1]); end
      // Player 1 holds both keys (NONE), player 2 holds down.
      b = ev_y.size();
      key_up = 2'b01;
      key_dn = 2'b11;
      step(3);
      tick_round(4);
      n_checks++; if (ev_y.size() - b != 1) begin n_fail++; $display("FAIL conflict_count got %0d exp 1", ev_y.size() - b); end
      else if (ev_p[b] !== 1'b1 || ev_y[b] !== 7'd56) begin
         n_fail++; $display("FAIL conflict_ev got p=%0b y=%0d exp 1/56", ev_p[b], ev_y[b]); end
      n_checks++; if (pad1_y !== 7'd54) begin n_fail++; $display("FAIL conflict_pad1 got %0d exp 54", pad1_y); end
   endtask

   task automatic test_game_run();
      int b, o;
      b = ev_y.size();
      o = ovr_cnt;
      game_run = 1'b0;
      tick_round(4);
      n_checks++; if (ev_y.size() != b || ovr_cnt != o) begin
         n_fail++; $display("FAIL run_low got %0d updates %0d overruns exp 0/0", ev_y.size() - b, ovr_cnt - o); end
      game_run = 1'b1;
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      game_run = 1'b0;
      step(4);
      n_checks++; if (ev_y.size() - b != 1) begin n_fail++; $display("FAIL run_fall_count got %0d exp 1", ev_y.size() - b); end
      else if (ev_p[b] !== 1'b1 || ev_y[b] !== 7'd58) begin
         n_fail++; $display("FAIL run_fall_ev got p=%0b y=%0d exp 1/58", ev_p[b], ev_y[b]); end
      game_run = 1'b1;
   endtask

   task automatic test_recenter();
      int b, o;
      key_up = 2'b01;
      key_dn = 2'b10;
      step(3);
      b = ev_y.size();
      o = ovr_cnt;
      frame_tick = 1'b1;
      recenter = 1'b1;
      step(1);
      frame_tick = 1'b0;
      recenter = 1'b0;
      step(4);
      n_checks++; if (ev_y.size() != b) begin n_fail++; $display("FAIL rc_tick_updates got %0d exp 0", ev_y.size() - b); end
      n_checks++; if (pad1_y !== 7'd56 || pad2_y !== 7'd56 || dbg_state !== 2'd0) begin
         n_fail++; $display("FAIL rc_tick got pads %0d/%0d state %0d exp 56/56/0", pad1_y, pad2_y, dbg_state); end
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      recenter = 1'b1;
      step(1);
      recenter = 1'b0;
      n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rc_arb1_state got %0d exp 0", dbg_state); end
      step(4);
      n_checks++; if (ev_y.size() != b || ovr_cnt != o) begin
         n_fail++; $display("FAIL rc_arb1_updates got %0d updates %0d overruns exp 0/0", ev_y.size() - b, ovr_cnt - o); end
      n_checks++; if (pad1_y !== 7'd56 || pad2_y !== 7'd56) begin
         n_fail++; $display("FAIL rc_arb1_pads got %0d/%0d exp 56/56", pad1_y, pad2_y); end
   endtask

   task automatic test_reset_mid_round();
      int b;
      tick_round(4);
      n_checks++; if (dbg_rr_ptr !== 1'b1) begin n_fail++; $display("FAIL pre_rst_rr got %0b exp 1", dbg_rr_ptr); end
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (pad1_y !== 7'd56 || pad2_y !== 7'd56 || dbg_state !== 2'd0 || dbg_rr_ptr !== 1'b0 || upd_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst got pads %0d/%0d state %0d rr %0b v %0b exp 56/56/0/0/0", pad1_y, pad2_y, dbg_state, dbg_rr_ptr, upd_valid); end
      step(2);
      rst = 1'b1;
      b = ev_y.size();
      step(6);
      n_checks++; if (ev_y.size() != b) begin n_fail++; $display("FAIL post_rst_idle got %0d updates exp 0", ev_y.size() - b); end
      tick_round(4);
      n_checks++; if (ev_y.size() - b != 2) begin n_fail++; $display("FAIL post_rst_count got %0d exp 2", ev_y.size() - b); end
      else if (ev_p[b] !== 1'b0 || ev_y[b] !== 7'd54 || ev_p[b+1] !== 1'b1 || ev_y[b+1] !== 7'd58) begin
         n_fail++; $display("FAIL post_rst_ev got %0b:%0d %0b:%0d exp 0:54 1:58", ev_p[b], ev_y[b], ev_p[b+1], ev_y[b+1]); end
      key_up = '0;
      key_dn = '0;
   endtask

   task automatic c_round();
      c_tick = 1'b1;
      step(1);
      c_tick = 1'b0;
      step(1);
   endtask

   task automatic test_clamp();
      c_key_up = 2'b01;
      step(3);
      c_round();
      n_checks++; if (c_upd_valid !== 1'b1 || c_upd_player !== 1'b0 || c_upd_y !== 7'd0 || c_pad1_y !== 7'd0) begin
         n_fail++; $display("FAIL clamp_low1 got v=%0b p=%0b y=%0d pad=%0d exp 1/0/0/0", c_upd_valid, c_upd_player, c_upd_y, c_pad1_y); end
      step(2);
      c_round();
      n_checks++; if (c_upd_valid !== 1'b1 || c_upd_y !== 7'd0 || c_pad1_y !== 7'd0) begin
         n_fail++; $display("FAIL clamp_low2 got v=%0b y=%0d pad=%0d exp 1/0/0", c_upd_valid, c_upd_y, c_pad1_y); end
      c_key_up = 2'b00;
      c_key_dn = 2'b10;
      step(3);
      for (int i = 0; i < 55; i++) begin
         c_round();
         step(1);
      end
      n_checks++; if (c_pad2_y !== 7'd111) begin n_fail++; $display("FAIL clamp_walk got %0d exp 111", c_pad2_y); end
      step(1);
      c_round();
      n_checks++; if (c_upd_valid !== 1'b1 || c_upd_player !== 1'b1 || c_upd_y !== 7'd112 || c_pad2_y !== 7'd112) begin
         n_fail++; $display("FAIL clamp_high1 got v=%0b p=%0b y=%0d pad=%0d exp 1/1/112/112", c_upd_valid, c_upd_player, c_upd_y, c_pad2_y); end
      step(2);
      c_round();
      n_checks++; if (c_upd_valid !== 1'b1 || c_upd_y !== 7'd112) begin
         n_fail++; $display("FAIL clamp_high2 got v=%0b y=%0d exp 1/112", c_upd_valid, c_upd_y); end
      step(2);
      n_checks++; if (c_dbg_state !== 2'd0 || c_tick_overrun !== 1'b0 || c_pad1_y !== 7'd0) begin
         n_fail++; $display("FAIL clamp_end got state %0d ovr %0b pad1 %0d exp 0/0/0", c_dbg_state, c_tick_overrun, c_pad1_y); end
      c_key_dn = 2'b00;
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_round_robin();
      test_overrun_conflict();
      test_game_run();
      test_recenter();
      test_reset_mid_round();
      test_clamp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
